// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - 4-digit seven-segment scan controller with frame-synchronous update
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100_000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_digits,
    input  logic        wr_blank_lz,
    output logic [6:0]  seven_seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp;
    logic          disp_lz;
    logic [15:0]   pend;
    logic          pend_lz;
    logic          pend_full;

    logic          slot_end;
    logic          boundary;
    logic [3:0]    nibble;
    logic [3:0]    blank;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    assign slot_end = (cnt == CNT_MAX);
    assign boundary = slot_end && (idx == 2'd3);
    assign wr_ready = reset && !pend_full;

    // A digit is blanked only if it and every higher digit are zero.
    assign blank[3] = disp_lz && (disp[15:12] == 4'd0);
    assign blank[2] = blank[3] && (disp[11:8] == 4'd0);
    assign blank[1] = blank[2] && (disp[7:4] == 4'd0);
    assign blank[0] = 1'b0;

    always_comb begin
        nibble = disp[3:0];
        case (idx)
            2'd0: nibble = disp[3:0];
            2'd1: nibble = disp[7:4];
            2'd2: nibble = disp[11:8];
            2'd3: nibble = disp[15:12];
            default: nibble = disp[3:0];
        endcase
    end

    always_comb begin
        seg_next = 7'b1111111;
        an_next  = 4'b1111;
        if (cnt >= DEAD && !blank[idx]) begin
            an_next = ~(4'b0001 << idx);
            case (nibble)
                4'd0: seg_next = 7'b0000001;
                4'd1: seg_next = 7'b1001111;
                4'd2: seg_next = 7'b0010010;
                4'd3: seg_next = 7'b0000110;
                4'd4: seg_next = 7'b1001100;
                4'd5: seg_next = 7'b0100100;
                4'd6: seg_next = 7'b0100000;
                4'd7: seg_next = 7'b0001111;
                4'd8: seg_next = 7'b0000000;
                4'd9: seg_next = 7'b0000100;
                default: seg_next = 7'b1111111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            idx        <= 2'd0;
            disp       <= 16'd0;
            disp_lz    <= 1'b0;
            pend       <= 16'd0;
            pend_lz    <= 1'b0;
            pend_full  <= 1'b0;
            an         <= 4'b1111;
            seven_seg  <= 7'b1111111;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seven_seg  <= seg_next;
            frame_done <= boundary;

            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // Pending data only moves to the display at a frame boundary.
            if (boundary && pend_full) begin
                disp      <= pend;
                disp_lz   <= pend_lz;
                pend_full <= 1'b0;
            end else if (wr_valid && wr_ready) begin
                pend      <= wr_digits;
                pend_lz   <= wr_blank_lz;
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;

    localparam int R = 8;
    localparam int D = 2;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_digits;
    logic        wr_blank_lz;
    logic [6:0]  seven_seg;
    logic [3:0]  an;
    logic        frame_done;

    seven_seg_scan_ctrl #(.REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
        .clk(clk),
        .reset(rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_digits(wr_digits),
        .wr_blank_lz(wr_blank_lz),
        .seven_seg(seven_seg),
        .an(an),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: p = cycles since reset release, display/pending values.
    int          p;
    logic [15:0] m_disp;
    logic        m_lz;
    logic [15:0] m_pend;
    logic        m_pend_lz;
    logic        m_pend_full;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fd;
    logic        last_acc;

    function automatic logic [6:0] dec(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h at p=%0d", tag, obs, exp, p);
        end
    endtask

    task automatic tick();
        logic        acc;
        logic [15:0] d;
        logic        l;
        int          c;
        int          ix;
        int          v;
        logic        bnd;
        acc = rst_n && wr_valid && !m_pend_full;
        d   = wr_digits;
        l   = wr_blank_lz;
        @(posedge clk);
        last_acc = acc;
        if (!rst_n) begin
            p = 0; m_disp = 0; m_lz = 0; m_pend_full = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_fd = 0;
        end else begin
            c   = p % R;
            ix  = (p / R) % 4;
            bnd = ((p % (4 * R)) == 4 * R - 1);
            v   = (m_disp >> (4 * ix)) & 15;
            if (c < D || (m_lz && ix > 0 && (m_disp >> (4 * ix)) == 0)) begin
                e_an = 4'hF; e_seg = 7'h7F;
            end else begin
                e_an  = 4'hF ^ (4'd1 << ix);
                e_seg = dec(v);
            end
            e_fd = bnd;
            if (bnd && m_pend_full) begin
                m_disp = m_pend; m_lz = m_pend_lz; m_pend_full = 0;
            end else if (acc) begin
                m_pend = d; m_pend_lz = l; m_pend_full = 1;
            end
            p++;
        end
        @(negedge clk);
        check("an", 16'(an), 16'(e_an));
        check("seven_seg", 16'(seven_seg), 16'(e_seg));
        check("frame_done", 16'(frame_done), 16'(e_fd));
        check("wr_ready", 16'(wr_ready), 16'(rst_n && !m_pend_full));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_write(input logic [15:0] v, input logic lz);
        int n;
        n = 0;
        wr_valid = 1'b1; wr_digits = v; wr_blank_lz = lz;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        total++;
        assert (last_acc) else begin
            bad++;
            $error("FAIL write_timeout: observed=not accepted expected=accepted value=%h", v);
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_slot(input int target);
        int n;
        n = 0;
        while (!(((p / R) % 4) == target && (p % R) == 3) && n < 100) begin
            tick();
            n++;
        end
        total++;
        assert (n < 100) else begin
            bad++;
            $error("FAIL wait_slot: observed=timeout expected=slot %0d", target);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_digits = 16'd0; wr_blank_lz = 1'b0;
        p = 0; m_disp = 0; m_lz = 0; m_pend = 0; m_pend_lz = 0; m_pend_full = 0;
        e_an = 4'hF; e_seg = 7'h7F; e_fd = 0; last_acc = 0;

        run(5);
        check("rst_an", 16'(an), 16'hF);
        check("rst_seg", 16'(seven_seg), 16'h7F);
        check("rst_ready", 16'(wr_ready), 16'h0);
        check("rst_fd", 16'(frame_done), 16'h0);

        rst_n = 1'b1;
        run(3);
        check("first_lit_an", 16'(an), 16'b1110);
        check("first_lit_seg", 16'(seven_seg), 16'b0000001);

        wait_slot(1);
        do_write(16'h1234, 1'b0);
        run(70);

        do_write(16'h1111, 1'b0);
        do_write(16'h2222, 1'b0);
        run(80);

        do_write(16'h0050, 1'b1); run(70);
        do_write(16'h0000, 1'b1); run(70);
        do_write(16'h0050, 1'b0); run(70);
        do_write(16'h00A9, 1'b0); run(70);

        wait_slot(1);
        do_write(16'h9999, 1'b0);
        run(4);
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(1);
        check("post_reset_ready", 16'(wr_ready), 16'h1);
        run(40);

        for (int k = 0; k < 40; k++) begin
            logic [15:0] v;
            run($urandom_range(0, 40));
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                run(2);
                rst_n = 1'b1;
            end
            v = 16'($urandom) >> (4 * $urandom_range(0, 4));
            do_write(v, 1'($urandom_range(0, 1)));
        end
        run(80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
